// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-arbiter state encoding.
package uart_pkg;
   localparam int CLOCKS_PER_BIT = 10;
   localparam int FRAME_BITS     = 10;

   typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP} arb_state_t;

   // (base + off) mod n, for base < n and off < n.
   function automatic int wrap_add(int base, int off, int n);
      return (base + off >= n) ? base + off - n : base + off;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: rotate valids so ptr sits at bit 0, take the lowest set bit, rotate back.
module rr_pick import uart_pkg::*; #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   logic [N-1:0]  rot;
   logic [IW-1:0] off;

   always_comb begin
      rot = '0;
      for (int k = 0; k < N; k++) rot[k] = valid_i[IW'(wrap_add(int'(ptr_i), k, N))];
      off = '0;
      for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
      idx_o = IW'(wrap_add(int'(ptr_i), int'(off), N));
      any_o = |valid_i;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams,
// holding the grant for a whole message and tracking the UART busy flag per frame.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int NUM_REQ      = 4,
   parameter int IDLE_GAP     = 0,
   parameter int LOCK_TIMEOUT = 1000,
   localparam int IW  = $clog2(NUM_REQ),
   localparam int LCW = $clog2(LOCK_TIMEOUT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           tx_byte_o,
   output logic                 tx_start_o,
   input  logic                 tx_busy_i,
   output logic [IW-1:0]        grant_id_o,
   output logic                 locked_o
);
   arb_state_t                state_q;
   logic [IW-1:0]             rr_ptr_q, grant_q;
   logic [7:0]                tx_byte_q, gap_cnt_q;
   logic [LCW-1:0]            lock_cnt_q;
   logic                      tx_start_q, locked_q, last_q;
   logic [NUM_REQ-1:0][7:0]   lanes;
   logic [IW-1:0]             pick_idx, cand, grant_nxt;
   logic                      pick_any, xfer;

   assign lanes     = req_data_i;
   assign grant_nxt = IW'(wrap_add(int'(grant_q), 1, NUM_REQ));

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // While locked only the owner may transfer; everyone else waits.
   always_comb begin
      cand        = locked_q ? grant_q : pick_idx;
      xfer        = (state_q == IDLE) && (locked_q ? req_valid_i[grant_q] : pick_any);
      req_ready_o = '0;
      if (xfer) req_ready_o[cand] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         tx_byte_q  <= 8'h00;
         tx_start_q <= 1'b0;
         locked_q   <= 1'b0;
         last_q     <= 1'b0;
         lock_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  tx_byte_q  <= lanes[cand];
                  grant_q    <= cand;
                  locked_q   <= ~req_last_i[cand];
                  last_q     <= req_last_i[cand];
                  lock_cnt_q <= '0;
                  tx_start_q <= 1'b1;
                  state_q    <= START;
               end else if (locked_q) begin
                  // A stalled owner loses its lock and drops to lowest priority.
                  if (lock_cnt_q == LCW'(LOCK_TIMEOUT - 1)) begin
                     locked_q   <= 1'b0;
                     rr_ptr_q   <= grant_nxt;
                     lock_cnt_q <= '0;
                  end else begin
                     lock_cnt_q <= lock_cnt_q + 1'b1;
                  end
               end else begin
                  lock_cnt_q <= '0;
               end
            end
            START:   state_q <= WAIT_HI;
            WAIT_HI: if (tx_busy_i) state_q <= WAIT_LO;
            WAIT_LO: begin
               if (!tx_busy_i) begin
                  if (last_q) rr_ptr_q <= grant_nxt;
                  gap_cnt_q <= '0;
                  state_q   <= (IDLE_GAP > 0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (gap_cnt_q == 8'(IDLE_GAP - 1)) state_q <= IDLE;
               else gap_cnt_q <= gap_cnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_byte_o  = tx_byte_q;
   assign tx_start_o = tx_start_q;
   assign grant_id_o = grant_q;
   assign locked_o   = locked_q;
endmodule
